div_sequencer: RTL and testbench

- Multi-cycle 32-bit radix-2 restoring divider with its own sequencing FSM.
- Serves the EX stage for DIV/DIVU. EX raises start and holds operands; the block asserts stall_request until the result is ready.
- Result ({remainder, quotient}) is destined for HI/LO via the EX write path.
- Supports signed/unsigned division and cancellation (annul) when the instruction is flushed.

---
 rtl/div_sequencer_pkg.sv | 23 ++
 rtl/div_sequencer_if.sv | 25 ++
 rtl/div_sequencer.sv | 119 +++++++++++
 tb/tb_div_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared encodings for the HI/LO divider: FSM states, ready levels, operator codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_sequencer_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'd0,
        DIV_BY_ZERO = 2'd1,
        DIV_ON      = 2'd2,
        DIV_END     = 2'd3
    } div_state_t;

    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;

    // Operator codes decoded in EX; they share the ALU operator field.
    localparam logic [5:0] ALU_OP_DIV  = 6'h1A;
    localparam logic [5:0] ALU_OP_DIVU = 6'h1B;

    // Result category steering the EX write path to HI/LO.
    localparam logic [2:0] ALU_CATEGORY_HILO = 3'd4;

endpackage

// File: rtl/div_sequencer_if.sv
// EX <-> divider handshake: start/annul request side and registered result side.
// Latency: n/a (wiring only).
// Backpressure: EX holds start and operands while stall_request is high.
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 signed_div;
    logic                 annul;
    logic [WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]     divisor;
    logic [2*WIDTH-1:0]   result;
    logic                 ready;
    logic                 stall_request;

    modport master (
        output start, signed_div, annul, dividend, divisor,
        input  result, ready, stall_request
    );

    modport slave (
        input  start, signed_div, annul, dividend, divisor,
        output result, ready, stall_request
    );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring divider for DIV/DIVU, result {remainder, quotient} for HI/LO.
// Latency: ready WIDTH+1 cycles after start is accepted, 2 cycles for divide by zero.
// Backpressure: stall_request holds EX until ready; result held while start stays high.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clock,
    input  logic           reset,
    div_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     dvd_q;
    logic [WIDTH-1:0]     dvs_q;
    logic                 q_neg_q;
    logic                 r_neg_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 ready_q;

    logic [WIDTH-1:0]     dividend_abs;
    logic [WIDTH-1:0]     divisor_abs;
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       trial;
    logic                 q_bit;
    logic [WIDTH-1:0]     rem_nxt;
    logic [WIDTH-1:0]     dvd_nxt;
    logic [WIDTH-1:0]     quo_fin;
    logic [WIDTH-1:0]     rem_fin;

    always_comb begin
        dividend_abs = (bus.signed_div && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
        divisor_abs  = (bus.signed_div && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

        // dvd_q doubles as the quotient: dividend bits shift out the top while
        // quotient bits shift in at the bottom.
        shifted = {rem_q, dvd_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        q_bit   = ~trial[WIDTH];
        rem_nxt = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_nxt = {dvd_q[WIDTH-2:0], q_bit};
        quo_fin = q_neg_q ? -dvd_nxt : dvd_nxt;
        rem_fin = r_neg_q ? -rem_nxt : rem_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= DIV_NOT_READY;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (bus.start && !bus.annul) begin
                        dvd_q   <= dividend_abs;
                        dvs_q   <= divisor_abs;
                        q_neg_q <= bus.signed_div & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        r_neg_q <= bus.signed_div & bus.dividend[WIDTH-1];
                        if (bus.divisor == '0) begin
                            state_q <= DIV_BY_ZERO;
                        end else begin
                            state_q <= DIV_ON;
                            cnt_q   <= '0;
                            rem_q   <= '0;
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    if (bus.annul) begin
                        state_q <= DIV_IDLE;
                    end else begin
                        state_q  <= DIV_END;
                        result_q <= '0;
                        ready_q  <= DIV_READY;
                    end
                end
                DIV_ON: begin
                    if (bus.annul) begin
                        state_q <= DIV_IDLE;
                    end else begin
                        rem_q <= rem_nxt;
                        dvd_q <= dvd_nxt;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_q  <= DIV_END;
                            result_q <= {rem_fin, quo_fin};
                            ready_q  <= DIV_READY;
                        end
                    end
                end
                DIV_END: begin
                    // Result stays on the bus until EX drops start or is flushed.
                    if (bus.annul || !bus.start) begin
                        state_q <= DIV_IDLE;
                        ready_q <= DIV_NOT_READY;
                    end
                end
                default: state_q <= DIV_IDLE;
            endcase
        end
    end

    assign bus.result        = result_q;
    assign bus.ready         = ready_q;
    assign bus.stall_request = bus.start & ~bus.annul & (state_q != DIV_END);

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: scoreboarded results, latency, handshake, annul, reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    div_sequencer_if #(.WIDTH(32)) bus ();

    div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [63:0] sb_q[$];
    logic [63:0] last_result;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference via 64-bit signed arithmetic, which truncates toward zero like DIV.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, input string tag);
        int          lat_exp;
        int          n;
        logic [63:0] exp;
        lat_exp        = (b == 32'd0) ? 2 : 33;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.signed_div = sgn;
        bus.annul      = 1'b0;
        bus.start      = 1'b1;
        sb_q.push_back(model(a, b, sgn));
        #1 check({tag, "_stall_T"}, 64'(bus.stall_request), 64'd1);
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (!bus.ready && n == 1) check({tag, "_stall_T1"}, 64'(bus.stall_request), 64'd1);
            // Operands are don't-care once accepted.
            bus.dividend = $urandom;
            bus.divisor  = $urandom;
        end while (!bus.ready && n < 40);
        check({tag, "_latency"}, 64'(n), 64'(lat_exp));
        exp = sb_q.pop_front();
        check({tag, "_result"}, bus.result, exp);
        check({tag, "_stall_rdy"}, 64'(bus.stall_request), 64'd0);
        repeat (3) begin
            @(negedge clock);
            check({tag, "_hold_rdy"}, 64'(bus.ready), 64'd1);
            check({tag, "_hold_res"}, bus.result, exp);
        end
        bus.start = 1'b0;
        @(negedge clock);
        check({tag, "_drop_rdy"}, 64'(bus.ready), 64'd0);
        check({tag, "_retain"}, bus.result, exp);
        last_result = exp;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.annul      = 1'b0;
        bus.signed_div = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        repeat (2) @(negedge clock);
        check("reset_ready", 64'(bus.ready), 64'd0);
        check("reset_result", bus.result, 64'd0);
        check("reset_stall", 64'(bus.stall_request), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        run_div(32'd100, 32'd7, 1'b0, "u100_7");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "s_m7_2");
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "s_7_m2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "u_big");
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "u_max_1");
        run_div(32'd5, 32'd0, 1'b0, "div0");
        run_div(32'hFFFF_FFF0, 32'd0, 1'b1, "div0_s");

        // Annul during ON: accepted at T, flushed at T+10, restart at T+12.
        bus.dividend = 32'd100; bus.divisor = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 5) check("annul_on_noready", 64'(bus.ready), 64'd0);
        end
        bus.annul = 1'b1;
        #1 check("annul_on_stall", 64'(bus.stall_request), 64'd0);
        @(negedge clock);
        bus.annul = 1'b0; bus.start = 1'b0;
        check("annul_on_ready", 64'(bus.ready), 64'd0);
        check("annul_on_res", bus.result, last_result);
        @(negedge clock);
        run_div(32'd20, 32'd3, 1'b0, "after_annul");

        // annul wins over start in IDLE; divisor 0 would give ready in 2 cycles.
        bus.dividend = 32'd5; bus.divisor = 32'd0; bus.start = 1'b1; bus.annul = 1'b1;
        #1 check("annul_idle_stall", 64'(bus.stall_request), 64'd0);
        @(negedge clock);
        bus.start = 1'b0; bus.annul = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("annul_idle_ready", 64'(bus.ready), 64'd0);
        end

        // Annul in BY_ZERO.
        bus.start = 1'b1;
        @(negedge clock);
        bus.annul = 1'b1;
        @(negedge clock);
        bus.annul = 1'b0; bus.start = 1'b0;
        check("annul_bz_ready", 64'(bus.ready), 64'd0);
        @(negedge clock);
        check("annul_bz_ready2", 64'(bus.ready), 64'd0);

        // Annul in END with start still held.
        bus.dividend = 32'd9; bus.divisor = 32'd4; bus.start = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.ready && n < 40);
        check("end_ready", 64'(bus.ready), 64'd1);
        check("end_result", bus.result, {32'd1, 32'd2});
        bus.annul = 1'b1;
        @(negedge clock);
        check("annul_end_ready", 64'(bus.ready), 64'd0);
        bus.annul = 1'b0; bus.start = 1'b0;
        @(negedge clock);

        // Synchronous reset mid-operation.
        bus.dividend = 32'd100; bus.divisor = 32'd7; bus.start = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b1; bus.start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_ready", 64'(bus.ready), 64'd0);
        check("midrst_result", bus.result, 64'd0);
        check("midrst_stall", 64'(bus.stall_request), 64'd0);
        run_div(32'd1000, 32'd10, 1'b0, "post_rst");
        run_div(32'd12345, 32'd0, 1'b1, "b2b_div0");
        run_div(32'hDEAD_BEEF, 32'hFFFF_0001, 1'b1, "b2b_s");

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
